// File: rtl/usb_packet_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : usb_packet_parser                                          |
// | Description : Walks a received USB packet held in a 32-bit word buffer,  |
// |               decodes PID and token/SOF fields, checks PID complement,   |
// |               length and CRC5/CRC16, and streams the data payload.       |
// | Ports       : clock48/reset          - clock, sync active-high reset     |
// |               packet_ready/_byte_count - packet handed over by receiver  |
// |               buffer_read_index/_data - word read port (1-cycle latency) |
// |               packet_consumed, busy  - buffer hand-back / activity       |
// |               pid, token_*, frame_number - decoded fields               |
// |               payload_valid/_byte    - data payload stream              |
// |               parse_done, error_flags - {overflow,length,crc,pid_check}  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module usb_packet_parser #(
   parameter int BUFFER_WORDS = 256
) (
   input  logic                            clock48,
   input  logic                            reset,
   input  logic                            packet_ready,
   input  logic [10:0]                     packet_byte_count,
   output logic [$clog2(BUFFER_WORDS)-1:0] buffer_read_index,
   input  logic [31:0]                     buffer_read_data,
   output logic                            packet_consumed,
   output logic                            busy,
   output logic [3:0]                      pid,
   output logic [6:0]                      token_address,
   output logic [3:0]                      token_endpoint,
   output logic [10:0]                     frame_number,
   output logic                            payload_valid,
   output logic [7:0]                      payload_byte,
   output logic                            parse_done,
   output logic [3:0]                      error_flags
);

   localparam int          C_IW        = $clog2(BUFFER_WORDS);
   localparam logic [31:0] C_MAX_BYTES = 32'(4 * BUFFER_WORDS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      WAIT   = 3'd2,
      BYTES  = 3'd3,
      FINISH = 3'd4
   } state_t;

   function automatic logic is_token(input logic [3:0] p);
      return (p == 4'h1) || (p == 4'h9) || (p == 4'hD) || (p == 4'h5);
   endfunction

   function automatic logic is_data(input logic [3:0] p);
      return (p == 4'h3) || (p == 4'hB);
   endfunction

   // Handshakes and unrecognised PIDs both need exactly one byte.
   function automatic logic len_ok(input logic [3:0] p, input logic [10:0] n);
      if (is_token(p)) return n == 11'd3;
      if (is_data(p))  return (n >= 11'd3) && (n <= 11'd67);
      return n == 11'd1;
   endfunction

   // Serial CRC5, bits fed LSB first, feedback from the register MSB.
   function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
      logic [4:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'b00101;
         else             r = {r[3:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   state_t           state_q,    state_d;
   logic [C_IW-1:0]  index_q,    index_d;
   logic [10:0]      count_q,    count_d;
   logic [10:0]      byte_idx_q, byte_idx_d;
   logic [3:0]       pid_q,      pid_d;
   logic [6:0]       addr_q,     addr_d;
   logic [3:0]       ep_q,       ep_d;
   logic [10:0]      frame_q,    frame_d;
   logic [3:0]       err_q,      err_d;
   logic [4:0]       crc5_q,     crc5_d;
   logic [15:0]      crc16_q,    crc16_d;
   logic [7:0]       hold0_q,    hold0_d;
   logic [7:0]       hold1_q,    hold1_d;
   logic             wait_low_q, wait_low_d;

   logic [7:0]       w_cur_byte;
   logic [3:0]       w_pid_eff;
   logic             w_last;
   logic [4:0]       w_crc5_next;
   logic [15:0]      w_crc16_next;

   assign w_cur_byte   = buffer_read_data[{byte_idx_q[1:0], 3'b000} +: 8];
   // On byte 0 the PID register is not loaded yet, so use the live byte.
   assign w_pid_eff    = (byte_idx_q == 11'd0) ? w_cur_byte[3:0] : pid_q;
   assign w_last       = (byte_idx_q == (count_q - 11'd1));
   assign w_crc5_next  = crc5_byte(crc5_q, w_cur_byte);
   assign w_crc16_next = crc16_byte(crc16_q, w_cur_byte);

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      pid_d      = pid_q;
      addr_d     = addr_q;
      ep_d       = ep_q;
      frame_d    = frame_q;
      err_d      = err_q;
      crc5_d     = crc5_q;
      crc16_d    = crc16_q;
      hold0_d    = hold0_q;
      hold1_d    = hold1_q;
      wait_low_d = wait_low_q;

      case (state_q)
         IDLE: begin
            if (!packet_ready) begin
               wait_low_d = 1'b0;
            end else if (!wait_low_q) begin
               index_d    = '0;
               byte_idx_d = '0;
               err_d      = '0;
               crc5_d     = 5'h1F;
               crc16_d    = 16'hFFFF;
               if ({21'd0, packet_byte_count} > C_MAX_BYTES) begin
                  err_d[3] = 1'b1;
                  count_d  = C_MAX_BYTES[10:0];
               end else begin
                  count_d  = packet_byte_count;
               end
               if (packet_byte_count == 11'd0) begin
                  err_d[2] = 1'b1;
                  state_d  = FINISH;
               end else begin
                  state_d  = FETCH;
               end
            end
         end

         FETCH: state_d = WAIT;

         WAIT:  state_d = BYTES;

         BYTES: begin
            byte_idx_d = byte_idx_q + 11'd1;
            // Two-byte delay line: a byte leaves only once two newer ones
            // exist, so the trailing CRC16 bytes never reach the payload.
            hold0_d    = hold1_q;
            hold1_d    = w_cur_byte;

            if (byte_idx_q == 11'd0) begin
               pid_d = w_cur_byte[3:0];
               if (w_cur_byte[7:4] != ~w_cur_byte[3:0]) err_d[0] = 1'b1;
               if (!len_ok(w_cur_byte[3:0], count_q))  err_d[2] = 1'b1;
            end else begin
               if (is_token(pid_q) && (byte_idx_q <= 11'd2)) crc5_d = w_crc5_next;
               if (is_data(pid_q)) crc16_d = w_crc16_next;
               if (is_token(pid_q) && (byte_idx_q == 11'd1)) begin
                  addr_d  = w_cur_byte[6:0];
                  ep_d[0] = w_cur_byte[7];
                  if (pid_q == 4'h5) frame_d[7:0] = w_cur_byte;
               end
               if (is_token(pid_q) && (byte_idx_q == 11'd2)) begin
                  ep_d[3:1] = w_cur_byte[2:0];
                  if (pid_q == 4'h5) frame_d[10:8] = w_cur_byte[2:0];
               end
            end

            if (w_last) begin
               state_d = FINISH;
               // CRC is only meaningful on a correctly sized packet.
               if (len_ok(w_pid_eff, count_q)) begin
                  if (is_token(w_pid_eff) && (w_crc5_next != 5'b01100))   err_d[1] = 1'b1;
                  if (is_data(w_pid_eff)  && (w_crc16_next != 16'h800D))  err_d[1] = 1'b1;
               end
            end else if (byte_idx_q[1:0] == 2'd3) begin
               index_d = index_q + C_IW'(1);
               state_d = FETCH;
            end
         end

         FINISH: begin
            // Receiver must drop packet_ready before the next hand-over.
            wait_low_d = 1'b1;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock48) begin
      if (reset) begin
         state_q    <= IDLE;
         index_q    <= '0;
         count_q    <= '0;
         byte_idx_q <= '0;
         pid_q      <= '0;
         addr_q     <= '0;
         ep_q       <= '0;
         frame_q    <= '0;
         err_q      <= '0;
         crc5_q     <= '0;
         crc16_q    <= '0;
         hold0_q    <= '0;
         hold1_q    <= '0;
         wait_low_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         pid_q      <= pid_d;
         addr_q     <= addr_d;
         ep_q       <= ep_d;
         frame_q    <= frame_d;
         err_q      <= err_d;
         crc5_q     <= crc5_d;
         crc16_q    <= crc16_d;
         hold0_q    <= hold0_d;
         hold1_q    <= hold1_d;
         wait_low_q <= wait_low_d;
      end
   end

   assign buffer_read_index = index_q;
   assign busy              = (state_q != IDLE);
   assign parse_done        = (state_q == FINISH);
   assign packet_consumed   = (state_q == FINISH);
   assign pid               = pid_q;
   assign token_address     = addr_q;
   assign token_endpoint    = ep_q;
   assign frame_number      = frame_q;
   assign error_flags       = err_q;
   assign payload_valid     = (state_q == BYTES) && is_data(pid_q) && (byte_idx_q >= 11'd3);
   assign payload_byte      = payload_valid ? hold0_q : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_usb_packet_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_usb_packet_parser                                       |
// | Description : Directed self-checking bench for usb_packet_parser with a  |
// |               small word buffer model (one-cycle read latency).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_usb_packet_parser;

   localparam int BW = 8;
   localparam int IW = $clog2(BW);

   logic          clk = 1'b0;
   logic          reset;
   logic          packet_ready;
   logic [10:0]   packet_byte_count;
   logic [IW-1:0] buffer_read_index;
   logic [31:0]   buffer_read_data;
   logic          packet_consumed;
   logic          busy;
   logic [3:0]    pid;
   logic [6:0]    token_address;
   logic [3:0]    token_endpoint;
   logic [10:0]   frame_number;
   logic          payload_valid;
   logic [7:0]    payload_byte;
   logic          parse_done;
   logic [3:0]    error_flags;

   usb_packet_parser #(.BUFFER_WORDS(BW)) dut (
      .clock48           (clk),
      .reset             (reset),
      .packet_ready      (packet_ready),
      .packet_byte_count (packet_byte_count),
      .buffer_read_index (buffer_read_index),
      .buffer_read_data  (buffer_read_data),
      .packet_consumed   (packet_consumed),
      .busy              (busy),
      .pid               (pid),
      .token_address     (token_address),
      .token_endpoint    (token_endpoint),
      .frame_number      (frame_number),
      .payload_valid     (payload_valid),
      .payload_byte      (payload_byte),
      .parse_done        (parse_done),
      .error_flags       (error_flags)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:BW-1];
   always @(posedge clk) buffer_read_data <= mem[buffer_read_index];

   int         vectors = 0;
   int         fails   = 0;
   logic [7:0] pay [0:63];
   int         lat, n_done, n_cons, n_pay;
   logic       got, reacc;

   // Bytes are given MSB-first in v: the first packet byte is the leftmost.
   task automatic load_mem(input logic [95:0] v, input int nb);
      for (int w = 0; w < BW; w++) mem[w] = 32'h0;
      for (int k = 0; k < nb; k++) mem[k/4][8*(k%4) +: 8] = v[8*(nb-1-k) +: 8];
   endtask

   // Hands one packet over and observes it until parse_done (bounded), then
   // keeps packet_ready high a few cycles to watch for an illegal re-accept.
   task automatic run_pkt(input logic [95:0] v, input int nb, input logic [10:0] cnt);
      load_mem(v, nb);
      @(negedge clk);
      packet_ready      = 1'b1;
      packet_byte_count = cnt;
      lat = 1; n_done = 0; n_cons = 0; n_pay = 0; got = 1'b0; reacc = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (c == 1) packet_byte_count = 11'h7FF;
         if (payload_valid) begin
            if (n_pay < 64) pay[n_pay] = payload_byte;
            n_pay++;
         end
         if (parse_done) begin
            n_done++;
            got = 1'b1;
         end
         if (packet_consumed) n_cons++;
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (parse_done)      n_done++;
         if (packet_consumed) n_cons++;
         if (payload_valid)   n_pay++;
         if (busy)            reacc = 1'b1;
      end
      packet_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1; packet_ready = 1'b0; packet_byte_count = '0;
      for (int w = 0; w < BW; w++) mem[w] = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, parse_done, packet_consumed, payload_valid} !== 4'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, parse_done, packet_consumed, payload_valid});
      end
      vectors++;
      if ({error_flags, pid, token_address, token_endpoint, frame_number} !== 30'h0) begin
         fails++; $display("FAIL reset_fields: got %h expected 0", {error_flags, pid, token_address, token_endpoint, frame_number});
      end
      vectors++;
      if (buffer_read_index !== '0) begin
         fails++; $display("FAIL reset_index: got %0d expected 0", buffer_read_index);
      end
   endtask

   task automatic test_setup;
      run_pkt(96'h2D0010, 3, 11'd3);
      vectors++;
      if (got !== 1'b1) begin fails++; $display("FAIL setup_timeout: got no parse_done expected one"); end
      vectors++;
      if ({pid, token_address, token_endpoint} !== 15'h6800) begin
         fails++; $display("FAIL setup_fields: got pid=%h addr=%h ep=%h expected d 00 0", pid, token_address, token_endpoint);
      end
      vectors++;
      if (error_flags !== 4'h0) begin fails++; $display("FAIL setup_flags: got %h expected 0", error_flags); end
      vectors++;
      if (n_done !== 1 || n_cons !== 1) begin
         fails++; $display("FAIL setup_pulses: got done=%0d consumed=%0d expected 1 1", n_done, n_cons);
      end
      vectors++;
      if (n_pay !== 0) begin fails++; $display("FAIL setup_payload: got %0d bytes expected 0", n_pay); end
      vectors++;
      if (reacc !== 1'b0) begin fails++; $display("FAIL setup_reaccept: got busy with ready held expected idle"); end
   endtask

   task automatic test_data0;
      logic [63:0] exp;
      exp = 64'h80_06_00_01_00_00_40_00;
      run_pkt(96'hC3_80_06_00_01_00_00_40_00_DD_94, 11, 11'd11);
      vectors++;
      if (n_pay !== 8) begin fails++; $display("FAIL data0_count: got %0d bytes expected 8", n_pay); end
      for (int i = 0; i < 8 && i < n_pay; i++) begin
         vectors++;
         if (pay[i] !== exp[8*(7-i) +: 8]) begin
            fails++; $display("FAIL data0_byte%0d: got %h expected %h", i, pay[i], exp[8*(7-i) +: 8]);
         end
      end
      vectors++;
      if (error_flags !== 4'h0 || pid !== 4'h3) begin
         fails++; $display("FAIL data0_status: got flags=%h pid=%h expected 0 3", error_flags, pid);
      end
   endtask

   task automatic test_ack;
      run_pkt(96'hD2, 1, 11'd1);
      vectors++;
      if (pid !== 4'h2 || error_flags !== 4'h0) begin
         fails++; $display("FAIL ack_status: got pid=%h flags=%h expected 2 0", pid, error_flags);
      end
      vectors++;
      if (lat !== 5) begin fails++; $display("FAIL ack_latency: got %0d cycles expected 5", lat); end
   endtask

   task automatic test_errors;
      run_pkt(96'h2D0011, 3, 11'd3);
      vectors++;
      if (error_flags !== 4'h2) begin fails++; $display("FAIL crc_flag: got %h expected 2", error_flags); end
      run_pkt(96'h2E0010, 3, 11'd3);
      vectors++;
      if (error_flags[0] !== 1'b1 || pid !== 4'hE) begin
         fails++; $display("FAIL pid_check: got flags=%h pid=%h expected bit0 set pid e", error_flags, pid);
      end
   endtask

   task automatic test_length;
      run_pkt(96'h4B00, 2, 11'd2);
      vectors++;
      if (error_flags[2] !== 1'b1) begin fails++; $display("FAIL len_short: got flags=%h expected bit2 set", error_flags); end
      run_pkt(96'h0, 0, 11'd0);
      vectors++;
      if (error_flags !== 4'h4) begin fails++; $display("FAIL len_zero_flags: got %h expected 4", error_flags); end
      vectors++;
      if (lat !== 2 || n_done !== 1) begin
         fails++; $display("FAIL len_zero_noread: got lat=%0d done=%0d expected 2 1", lat, n_done);
      end
   endtask

   task automatic test_overflow;
      run_pkt(96'hD2, 1, 11'd40);
      vectors++;
      if (error_flags[3] !== 1'b1 || error_flags[2] !== 1'b1) begin
         fails++; $display("FAIL overflow: got flags=%h expected bits 3 and 2 set", error_flags);
      end
   endtask

   task automatic test_sof;
      run_pkt(96'hA5_23_01, 3, 11'd3);
      vectors++;
      if (frame_number !== 11'h123 || token_address !== 7'h23 || token_endpoint !== 4'h2) begin
         fails++; $display("FAIL sof_fields: got frame=%h addr=%h ep=%h expected 123 23 2", frame_number, token_address, token_endpoint);
      end
   endtask

   task automatic test_back_to_back;
      run_pkt(96'hD2, 1, 11'd1);
      run_pkt(96'h5A, 1, 11'd1);
      vectors++;
      if (pid !== 4'hA || error_flags !== 4'h0 || n_done !== 1) begin
         fails++; $display("FAIL b2b_nak: got pid=%h flags=%h done=%0d expected a 0 1", pid, error_flags, n_done);
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      load_mem(96'hC3_80_06_00_01_00_00_40_00_DD_94, 11);
      @(negedge clk);
      packet_ready      = 1'b1;
      packet_byte_count = 11'd11;
      repeat (4) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || pid !== 4'h3) begin
         fails++; $display("FAIL rmid_inflight: got busy=%b pid=%h expected 1 3", busy, pid);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if ({busy, parse_done, packet_consumed, payload_valid, error_flags, pid, token_address,
           token_endpoint, frame_number, buffer_read_index} !== '0) begin
         fails++; $display("FAIL rmid_cleared: outputs nonzero after reset expected all 0");
      end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (busy || packet_consumed) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin fails++; $display("FAIL rmid_noaccept: got activity with ready held expected none"); end
      packet_ready = 1'b0;
      @(negedge clk);
      run_pkt(96'hC3_80_06_00_01_00_00_40_00_DD_94, 11, 11'd11);
      vectors++;
      if (got !== 1'b1 || n_pay !== 8 || error_flags !== 4'h0) begin
         fails++; $display("FAIL rmid_reaccept: got done=%b bytes=%0d flags=%h expected 1 8 0", got, n_pay, error_flags);
      end
   endtask

   initial begin
      test_reset;
      test_setup;
      test_data0;
      test_ack;
      test_errors;
      test_length;
      test_overflow;
      test_sof;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
